// File: rtl/demux_1x2_buf.sv
// 1-to-2 demultiplexer with a 2-entry valid/ready FIFO on each output.
// Optional per-output pop counters are enabled by defining DEMUX_CNT_EN.

module demux_1x2_buf_fifo #(
    parameter int P = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [P-1:0] i_din,
    output logic [P-1:0] o_dout,
    output logic         o_valid,
    output logic         o_full
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_TWO
    } state_t;

    state_t         r_state;
    logic   [P-1:0] r_head;
    logic   [P-1:0] r_tail;

    // The head register drives the output directly; it keeps the last
    // popped word while the FIFO is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            unique case (r_state)
                S_EMPTY: begin
                    if (i_push) begin
                        r_head  <= i_din;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    case ({i_push, i_pop})
                        2'b11: r_head <= i_din;
                        2'b10: begin
                            r_tail  <= i_din;
                            r_state <= S_TWO;
                        end
                        2'b01: r_state <= S_EMPTY;
                        default: ;
                    endcase
                end
                S_TWO: begin
                    if (i_pop) begin
                        r_head <= r_tail;
                        if (i_push) r_tail  <= i_din;
                        else        r_state <= S_ONE;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign o_dout  = r_head;
    assign o_valid = (r_state != S_EMPTY);
    assign o_full  = (r_state == S_TWO);

endmodule

module demux_1x2_buf #(
    parameter int P  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          MS,
    input  logic [P-1:0]  D_in,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [P-1:0]  D_out0,
    output logic          valid0,
    input  logic          ready0,
    output logic [P-1:0]  D_out1,
    output logic          valid1,
    input  logic          ready1
`ifdef DEMUX_CNT_EN
    ,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
`endif
);

    logic w_pop0;
    logic w_pop1;
    logic w_push0;
    logic w_push1;
    logic w_full0;
    logic w_full1;
    logic w_rdy0;
    logic w_rdy1;

    assign w_pop0 = valid0 & ready0;
    assign w_pop1 = valid1 & ready1;

    // A full FIFO still accepts when its head leaves in the same cycle.
    assign w_rdy0 = ~w_full0 | w_pop0;
    assign w_rdy1 = ~w_full1 | w_pop1;

    assign in_ready = MS ? w_rdy1 : w_rdy0;

    assign w_push0 = in_valid & ~MS & w_rdy0;
    assign w_push1 = in_valid &  MS & w_rdy1;

    demux_1x2_buf_fifo #(.P(P)) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push0),
        .i_pop   (w_pop0),
        .i_din   (D_in),
        .o_dout  (D_out0),
        .o_valid (valid0),
        .o_full  (w_full0)
    );

    demux_1x2_buf_fifo #(.P(P)) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push1),
        .i_pop   (w_pop1),
        .i_din   (D_in),
        .o_dout  (D_out1),
        .o_valid (valid1),
        .o_full  (w_full1)
    );

`ifdef DEMUX_CNT_EN
    logic [CW-1:0] r_cnt0;
    logic [CW-1:0] r_cnt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_pop0) r_cnt0 <= r_cnt0 + CW'(1);
            if (w_pop1) r_cnt1 <= r_cnt1 + CW'(1);
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule
